seg7_scan_decoder: RTL and testbench
====================================

Name: seg7_scan_decoder

Overview:
- Inverse of the board's hex-to-7-segment encoding: samples a time-multiplexed, active-low 7-segment bus (segments plus one-hot digit select) and recovers the hex nibble per digit.
- Debounces each digit with a consecutive-match counter.
- Presents the assembled value to a monitor/logger through a valid/ready handshake.
- Used for self-test loopback of display drivers and for reading external 7-segment instruments.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits; width of iDIG_SEL and oDIG_VALID.
- STABLE_COUNT, 3, consecutive identical samples required before a digit commits (min 1, max 255).

Ports:
- iCLK  input  1  system clock
- iRST_N  input  1  synchronous, active-low reset
- iSEG  input  7  segment lines, active-low; bit0 top, bit1 upper-right, bit2 lower-right, bit3 bottom, bit4 lower-left, bit5 upper-left, bit6 middle
- iSEG_DP  input  1  decimal point, active-low
- iDIG_SEL  input  NUM_DIGITS  one-hot digit select, active-high
- iSAMPLE  input  1  qualifies iSEG/iDIG_SEL for one cycle
- oVALUE  output  4*NUM_DIGITS  snapshot of decoded nibbles; digit n at [4n+3:4n]
- oDIG_VALID  output  NUM_DIGITS  snapshot; 1 = digit decoded to a legal hex glyph
- oDP  output  NUM_DIGITS  snapshot decimal points (see Optional Feature)
- oVALID  output  1  snapshot available
- iREADY  input  1  consumer accepts snapshot
- oERR_SEL  output  1  one-cycle pulse: sample discarded for a bad select

Behaviour:
- Reset (iRST_N low at an iCLK edge):
  - oVALUE=0, oDIG_VALID=0, oDP=0, oVALID=0, oERR_SEL=0.
  - Per-digit last pattern=7'h7F, count=0, committed nibble=0, committed valid=0, change flag=0.
  - Reset mid-handshake drops oVALID without a transfer.
- Sample acceptance:
  - A sample is taken on an edge with iSAMPLE=1 and exactly one iDIG_SEL bit set.
  - iSAMPLE=1 with zero or multiple select bits: sample discarded; oERR_SEL=1 the next cycle only; no per-digit state changes.
- Decode table (pattern -> nibble):
  - 1000000->0, 1111001->1, 0100100->2, 0110000->3
  - 0011001->4, 0010010->5, 0000010->6, 1111000->7
  - 0000000->8, 0011000->9, 0001000->A, 0000011->B
  - 1000110->C, 0100001->D, 0000110->E, 0001110->F
  - Any other pattern, including blank 1111111: nibble 0, valid 0.
- Per-digit stability:
  - Accepted pattern equal to stored pattern: count increments, saturating at STABLE_COUNT.
  - Different pattern: store it, count=1.
  - Commit only on the edge where count becomes STABLE_COUNT (transition, not level). Committed nibble/valid update on that same edge.
  - A commit that changes committed nibble, valid or DP sets the change flag. Re-committing identical data does not set it.
- Output handshake:
  - oVALID=0 and change flag=1: next edge loads the snapshot from all committed digits, sets oVALID=1, clears the flag.
  - While oVALID=1 and iREADY=0: snapshot and oVALID hold; further commits only set the flag.
  - oVALID=1 and iREADY=1: transfer completes and oVALID=0 next edge.
  - oVALID stays low at least one cycle between transfers. A pending flag reloads the snapshot on the following edge.
  - Latency: the STABLE_COUNT-th matching sample commits at edge t; oVALID=1 after edge t+1.
- Simultaneous events:
  - A commit on the same edge as a snapshot load is not in that snapshot; its flag stays set.
  - A commit on the edge a transfer completes sets the flag for the next snapshot.

Optional Feature:
- Macro: SEG7_DP_CAPTURE_EN.
- Defined:
  - iSEG_DP is part of the stored per-digit pattern (8 bits); a DP change alone resets the count.
  - Committed DP (active-high, inverted from the bus) appears on oDP[n] in the snapshot.
- Undefined:
  - iSEG_DP is ignored and only 7 pattern bits are stored.
  - oDP tied to 0.

Test Plan (NUM_DIGITS=4, STABLE_COUNT=3):
- Reset: iRST_N low 2 cycles with iSAMPLE toggling -> all outputs 0, oVALID stays 0.
- Commit: iDIG_SEL=0001, iSEG=0100100 sampled 3 times, iREADY=1 -> oVALID one edge after the 3rd sample; oVALUE=16'h0002, oDIG_VALID=0001; oVALID lasts 1 cycle.
- Glitch: digit 0 fed 0000000 x2, 1111001 x1, 0000000 x3 -> no commit until the last triple; oVALUE[3:0]=8 with exactly one transfer.
- Backpressure: iREADY=0; commit digit1=0001000 (A), then digit2=0001110 (F) -> snapshot holds 16'h00A0. Raise iREADY one cycle -> oVALID low one cycle, then oVALUE=16'h0FA0.
- Bad select: iSAMPLE with iDIG_SEL=0011, then 0000 -> oERR_SEL pulses twice; interleaved valid samples still commit after exactly 3 matches.
- Illegal glyph: digit 3 committed to 3, then fed 1010101 x3 -> oDIG_VALID[3]=0, oVALUE[15:12]=0, new transfer. With SEG7_DP_CAPTURE_EN: DP toggles restart counting and oDP[3]=1 after 3 stable samples with iSEG_DP=0.

Source files
------------

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
// Samples a time-multiplexed, active-low 7-segment bus and recovers one hex
// nibble per digit. Each digit is debounced by a consecutive-match counter.
// The committed digits are offered to a consumer as a snapshot through a
// valid/ready handshake.
// Optional feature macro: SEG7_DP_CAPTURE_EN. When it is defined, the decimal
// point is captured and debounced as part of each digit's pattern. When it is
// undefined, the decimal point is ignored and oDP is held at zero.
module seg7_scan_decoder #(
    parameter int NUM_DIGITS   = 4,
    parameter int STABLE_COUNT = 3
) (
    input  logic                      iCLK,
    input  logic                      iRST_N,
    input  logic [6:0]                iSEG,
    input  logic                      iSEG_DP,
    input  logic [NUM_DIGITS-1:0]     iDIG_SEL,
    input  logic                      iSAMPLE,
    output logic [4*NUM_DIGITS-1:0]   oVALUE,
    output logic [NUM_DIGITS-1:0]     oDIG_VALID,
    output logic [NUM_DIGITS-1:0]     oDP,
    output logic                      oVALID,
    input  logic                      iREADY,
    output logic                      oERR_SEL
);

`ifdef SEG7_DP_CAPTURE_EN
    localparam int PW = 8;
`else
    localparam int PW = 7;
`endif
    localparam logic [PW-1:0] PAT_BLANK = {PW{1'b1}};
    localparam logic [7:0]    SC8       = 8'(STABLE_COUNT);

    // Returns {legal, nibble} for an active-low segment pattern (bit6 = middle).
    function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'b1000000: r = 5'h10;
            7'b1111001: r = 5'h11;
            7'b0100100: r = 5'h12;
            7'b0110000: r = 5'h13;
            7'b0011001: r = 5'h14;
            7'b0010010: r = 5'h15;
            7'b0000010: r = 5'h16;
            7'b1111000: r = 5'h17;
            7'b0000000: r = 5'h18;
            7'b0011000: r = 5'h19;
            7'b0001000: r = 5'h1A;
            7'b0000011: r = 5'h1B;
            7'b1000110: r = 5'h1C;
            7'b0100001: r = 5'h1D;
            7'b0000110: r = 5'h1E;
            7'b0001110: r = 5'h1F;
            default:    r = 5'h00;
        endcase
        return r;
    endfunction

    // Per-digit debounce and commit state.
    logic [PW-1:0]           pat_q [NUM_DIGITS];
    logic [PW-1:0]           pat_d [NUM_DIGITS];
    logic [7:0]              cnt_q [NUM_DIGITS];
    logic [7:0]              cnt_d [NUM_DIGITS];
    logic [3:0]              nib_q [NUM_DIGITS];
    logic [3:0]              nib_d [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   vld_q, vld_d;
    logic [NUM_DIGITS-1:0]   dpc_q, dpc_d;

    // Handshake and snapshot state.
    logic                    chg_q, chg_d;
    logic                    ovalid_q, ovalid_d;
    logic [4*NUM_DIGITS-1:0] val_q, val_d;
    logic [NUM_DIGITS-1:0]   dvalid_q, dvalid_d;
    logic [NUM_DIGITS-1:0]   dpo_q, dpo_d;
    logic                    err_q, err_d;

    logic                    sel_ok_s;
    logic                    accept_s;
    logic [PW-1:0]           sample_pat_s;
    logic                    commit_chg_s;

`ifdef SEG7_DP_CAPTURE_EN
    assign sample_pat_s = {iSEG_DP, iSEG};
`else
    logic unused_dp_s;
    assign unused_dp_s  = iSEG_DP;
    assign sample_pat_s = iSEG;
`endif

    // Qualify the sample: exactly one select bit must be set.
    always_comb begin
        sel_ok_s = ($countones(iDIG_SEL) == 32'd1);
        accept_s = iSAMPLE && sel_ok_s;
        err_d    = iSAMPLE && !sel_ok_s;
    end

    // Per-digit match counting, commit on reaching the threshold, change detection.
    always_comb begin
        logic       commit_v;
        logic [4:0] glyph_v;
        logic       dp_v;
        commit_chg_s = 1'b0;
        commit_v     = 1'b0;
        glyph_v      = 5'h00;
        dp_v         = 1'b0;
        for (int n = 0; n < NUM_DIGITS; n++) begin
            pat_d[n] = pat_q[n];
            cnt_d[n] = cnt_q[n];
            nib_d[n] = nib_q[n];
            vld_d[n] = vld_q[n];
            dpc_d[n] = dpc_q[n];
            commit_v = 1'b0;
            if (accept_s && iDIG_SEL[n]) begin
                if (sample_pat_s == pat_q[n]) begin
                    if (cnt_q[n] < SC8) begin
                        cnt_d[n] = cnt_q[n] + 8'd1;
                        commit_v = ((cnt_q[n] + 8'd1) == SC8);
                    end else begin
                        cnt_d[n] = cnt_q[n];
                    end
                end else begin
                    pat_d[n] = sample_pat_s;
                    cnt_d[n] = 8'd1;
                    commit_v = (SC8 == 8'd1);
                end
            end else begin
                commit_v = 1'b0;
            end
            glyph_v = decode_glyph(sample_pat_s[6:0]);
`ifdef SEG7_DP_CAPTURE_EN
            dp_v = ~sample_pat_s[7];
`else
            dp_v = 1'b0;
`endif
            if (commit_v) begin
                nib_d[n] = glyph_v[3:0];
                vld_d[n] = glyph_v[4];
                dpc_d[n] = dp_v;
                if ((glyph_v[3:0] != nib_q[n]) || (glyph_v[4] != vld_q[n]) || (dp_v != dpc_q[n])) begin
                    commit_chg_s = 1'b1;
                end else begin
                    commit_chg_s = commit_chg_s;
                end
            end else begin
                commit_chg_s = commit_chg_s;
            end
        end
    end

    // Snapshot load / transfer handshake; a same-edge commit keeps the flag set.
    always_comb begin
        chg_d    = chg_q;
        ovalid_d = ovalid_q;
        val_d    = val_q;
        dvalid_d = dvalid_q;
        dpo_d    = dpo_q;
        if (ovalid_q) begin
            if (iREADY) begin
                ovalid_d = 1'b0;
            end else begin
                ovalid_d = 1'b1;
            end
        end else if (chg_q) begin
            ovalid_d = 1'b1;
            chg_d    = 1'b0;
            for (int n = 0; n < NUM_DIGITS; n++) begin
                val_d[4*n +: 4] = nib_q[n];
                dvalid_d[n]     = vld_q[n];
                dpo_d[n]        = dpc_q[n];
            end
        end else begin
            ovalid_d = 1'b0;
        end
        if (commit_chg_s) begin
            chg_d = 1'b1;
        end else begin
            chg_d = chg_d;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            for (int n = 0; n < NUM_DIGITS; n++) begin
                pat_q[n] <= PAT_BLANK;
                cnt_q[n] <= 8'd0;
                nib_q[n] <= 4'd0;
            end
            vld_q    <= '0;
            dpc_q    <= '0;
            chg_q    <= 1'b0;
            ovalid_q <= 1'b0;
            val_q    <= '0;
            dvalid_q <= '0;
            dpo_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            for (int n = 0; n < NUM_DIGITS; n++) begin
                pat_q[n] <= pat_d[n];
                cnt_q[n] <= cnt_d[n];
                nib_q[n] <= nib_d[n];
            end
            vld_q    <= vld_d;
            dpc_q    <= dpc_d;
            chg_q    <= chg_d;
            ovalid_q <= ovalid_d;
            val_q    <= val_d;
            dvalid_q <= dvalid_d;
            dpo_q    <= dpo_d;
            err_q    <= err_d;
        end
    end

    assign oVALUE     = val_q;
    assign oDIG_VALID = dvalid_q;
    assign oVALID     = ovalid_q;
    assign oERR_SEL   = err_q;
`ifdef SEG7_DP_CAPTURE_EN
    assign oDP        = dpo_q;
`else
    assign oDP        = '0;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: directed steps followed by
// randomized traffic, every cycle compared against a behavioural model.
module tb_seg7_scan_decoder;
    localparam int ND = 4;
    localparam int SC = 3;
`ifdef SEG7_DP_CAPTURE_EN
    localparam bit DP_EN = 1'b1;
`else
    localparam bit DP_EN = 1'b0;
`endif

    logic          iCLK = 1'b0;
    logic          iRST_N;
    logic [6:0]    iSEG;
    logic          iSEG_DP;
    logic [ND-1:0] iDIG_SEL;
    logic          iSAMPLE;
    logic [4*ND-1:0] oVALUE;
    logic [ND-1:0] oDIG_VALID;
    logic [ND-1:0] oDP;
    logic          oVALID;
    logic          iREADY;
    logic          oERR_SEL;

    int errors = 0;
    int checks = 0;
    int xfers  = 0;

    seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_COUNT(SC)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iSEG(iSEG), .iSEG_DP(iSEG_DP),
        .iDIG_SEL(iDIG_SEL), .iSAMPLE(iSAMPLE), .oVALUE(oVALUE),
        .oDIG_VALID(oDIG_VALID), .oDP(oDP), .oVALID(oVALID),
        .iREADY(iREADY), .oERR_SEL(oERR_SEL)
    );

    always #5 iCLK = ~iCLK;

    // Glyph table indexed by nibble value.
    logic [6:0] glyph_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // Behavioural model state.
    logic [7:0]    m_pat [ND];
    int            m_cnt [ND];
    logic [3:0]    m_nib [ND];
    logic          m_vld [ND];
    logic          m_dp  [ND];
    logic          m_chg, m_ovalid, m_err;
    logic [4*ND-1:0] m_val;
    logic [ND-1:0] m_dvalid, m_dpo;

    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        for (int i = 0; i < 16; i++) begin
            if (glyph_tab[i] == p) return {1'b1, 4'(i)};
        end
        return 5'd0;
    endfunction

    task automatic model_step();
        int d;
        logic [7:0] p;
        logic [4:0] g;
        logic cdp;
        bit commit;
        if (!iRST_N) begin
            for (int k = 0; k < ND; k++) begin
                m_pat[k] = 8'hFF; m_cnt[k] = 0; m_nib[k] = 4'd0; m_vld[k] = 1'b0; m_dp[k] = 1'b0;
            end
            m_chg = 1'b0; m_ovalid = 1'b0; m_err = 1'b0;
            m_val = '0; m_dvalid = '0; m_dpo = '0;
            return;
        end
        m_err = iSAMPLE && ($countones(iDIG_SEL) != 1);
        if (m_ovalid) begin
            if (iREADY) m_ovalid = 1'b0;
        end else if (m_chg) begin
            for (int k = 0; k < ND; k++) begin
                m_val[4*k +: 4] = m_nib[k];
                m_dvalid[k] = m_vld[k];
                m_dpo[k] = m_dp[k];
            end
            m_chg = 1'b0;
            m_ovalid = 1'b1;
        end
        if (iSAMPLE && ($countones(iDIG_SEL) == 1)) begin
            d = 0;
            for (int k = 0; k < ND; k++) if (iDIG_SEL[k]) d = k;
            p = {(DP_EN ? iSEG_DP : 1'b1), iSEG};
            commit = 1'b0;
            if (p == m_pat[d]) begin
                if (m_cnt[d] < SC) begin
                    m_cnt[d]++;
                    commit = (m_cnt[d] == SC);
                end
            end else begin
                m_pat[d] = p;
                m_cnt[d] = 1;
                commit = (SC == 1);
            end
            if (commit) begin
                g = ref_decode(p[6:0]);
                cdp = DP_EN ? ~p[7] : 1'b0;
                if (g[3:0] != m_nib[d] || g[4] != m_vld[d] || cdp != m_dp[d]) m_chg = 1'b1;
                m_nib[d] = g[3:0]; m_vld[d] = g[4]; m_dp[d] = cdp;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic samp, input logic [ND-1:0] sel, input logic [6:0] seg,
                         input logic dp, input logic rdy);
        iSAMPLE = samp; iDIG_SEL = sel; iSEG = seg; iSEG_DP = dp; iREADY = rdy;
        if (oVALID && rdy && iRST_N) xfers++;
        @(posedge iCLK);
        model_step();
        #1;
        check("value",     32'(oVALUE),     32'(m_val));
        check("dig_valid", 32'(oDIG_VALID), 32'(m_dvalid));
        check("dp",        32'(oDP),        32'(m_dpo));
        check("valid",     32'(oVALID),     32'(m_ovalid));
        check("err_sel",   32'(oERR_SEL),   32'(m_err));
    endtask

    task automatic sample3(input logic [ND-1:0] sel, input logic [6:0] seg, input logic dp, input logic rdy);
        for (int i = 0; i < 3; i++) cycle(1'b1, sel, seg, dp, rdy);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 4'b0000, 7'b1111111, 1'b1, rdy);
    endtask

    logic [6:0] cur_seg [ND];
    logic       cur_dp;

    initial begin
        iRST_N = 1'b0; iSAMPLE = 1'b0; iDIG_SEL = '0; iSEG = 7'h7F; iSEG_DP = 1'b1; iREADY = 1'b0;

        // Reset with iSAMPLE toggling.
        cycle(1'b1, 4'b0001, 7'b0100100, 1'b1, 1'b1);
        cycle(1'b0, 4'b0001, 7'b0100100, 1'b1, 1'b1);
        check("rst_valid", 32'(oVALID), 32'd0);
        check("rst_value", 32'(oVALUE), 32'd0);
        check("rst_err",   32'(oERR_SEL), 32'd0);
        iRST_N = 1'b1;

        // Basic commit and latency.
        sample3(4'b0001, 7'b0100100, 1'b1, 1'b1);
        check("commit_lat0", 32'(oVALID), 32'd0);
        idle(1, 1'b1);
        check("commit_valid", 32'(oVALID), 32'd1);
        check("commit_value", 32'(oVALUE), 32'h0002);
        check("commit_dv",    32'(oDIG_VALID), 32'h1);
        idle(1, 1'b1);
        check("commit_pulse", 32'(oVALID), 32'd0);

        // Glitch in the middle of a run.
        xfers = 0;
        cycle(1'b1, 4'b0001, 7'b0000000, 1'b1, 1'b1);
        cycle(1'b1, 4'b0001, 7'b0000000, 1'b1, 1'b1);
        cycle(1'b1, 4'b0001, 7'b1111001, 1'b1, 1'b1);
        check("glitch_nocommit", 32'(oVALID), 32'd0);
        sample3(4'b0001, 7'b0000000, 1'b1, 1'b1);
        idle(3, 1'b1);
        check("glitch_xfers", 32'(xfers), 32'd1);
        check("glitch_nib",   32'(oVALUE[3:0]), 32'h8);

        // Backpressure: snapshot holds, later commit reloads after a gap.
        sample3(4'b0010, 7'b0001000, 1'b1, 1'b0);
        idle(2, 1'b0);
        check("bp_valid1", 32'(oVALID), 32'd1);
        check("bp_value1", 32'(oVALUE), 32'h00A8);
        sample3(4'b0100, 7'b0001110, 1'b1, 1'b0);
        idle(1, 1'b0);
        check("bp_hold", 32'(oVALUE), 32'h00A8);
        idle(1, 1'b1);
        check("bp_gap", 32'(oVALID), 32'd0);
        idle(1, 1'b0);
        check("bp_valid2", 32'(oVALID), 32'd1);
        check("bp_value2", 32'(oVALUE), 32'h0FA8);
        idle(2, 1'b1);

        // Bad selects interleaved with valid samples.
        cycle(1'b1, 4'b1000, 7'b0110000, 1'b1, 1'b1);
        cycle(1'b1, 4'b0011, 7'b0110000, 1'b1, 1'b1);
        check("badsel_err1", 32'(oERR_SEL), 32'd1);
        cycle(1'b1, 4'b1000, 7'b0110000, 1'b1, 1'b1);
        check("badsel_clr", 32'(oERR_SEL), 32'd0);
        cycle(1'b1, 4'b0000, 7'b0110000, 1'b1, 1'b1);
        check("badsel_err2", 32'(oERR_SEL), 32'd1);
        check("badsel_nocommit", 32'(oVALID), 32'd0);
        cycle(1'b1, 4'b1000, 7'b0110000, 1'b1, 1'b1);
        idle(1, 1'b1);
        check("badsel_valid", 32'(oVALID), 32'd1);
        check("badsel_nib3", 32'(oVALUE[15:12]), 32'h3);
        idle(1, 1'b1);

        // Illegal glyph on digit 3.
        sample3(4'b1000, 7'b1010101, 1'b1, 1'b1);
        idle(1, 1'b1);
        check("illegal_valid", 32'(oVALID), 32'd1);
        check("illegal_dv3",   32'(oDIG_VALID[3]), 32'd0);
        check("illegal_nib3",  32'(oVALUE[15:12]), 32'h0);
        idle(1, 1'b1);

        // Decimal-point toggles restart counting when captured.
        cycle(1'b1, 4'b1000, 7'b1010101, 1'b0, 1'b1);
        cycle(1'b1, 4'b1000, 7'b1010101, 1'b0, 1'b1);
        cycle(1'b1, 4'b1000, 7'b1010101, 1'b1, 1'b1);
        sample3(4'b1000, 7'b1010101, 1'b0, 1'b1);
        idle(1, 1'b1);
`ifdef SEG7_DP_CAPTURE_EN
        check("dp_valid", 32'(oVALID), 32'd1);
        check("dp3",      32'(oDP[3]), 32'd1);
`else
        check("dp_ignored", 32'(oVALID), 32'd0);
`endif
        idle(2, 1'b1);

        // Reset while a snapshot is pending drops oVALID.
        sample3(4'b0001, 7'b0011001, 1'b1, 1'b0);
        idle(1, 1'b0);
        check("rstmid_valid", 32'(oVALID), 32'd1);
        iRST_N = 1'b0;
        idle(1, 1'b0);
        check("rstmid_drop",  32'(oVALID), 32'd0);
        check("rstmid_value", 32'(oVALUE), 32'd0);
        iRST_N = 1'b1;
        idle(2, 1'b1);

        // Randomized traffic against the model.
        for (int k = 0; k < ND; k++) cur_seg[k] = glyph_tab[$urandom_range(0, 15)];
        cur_dp = 1'b1;
        for (int i = 0; i < 800; i++) begin
            int d;
            logic [ND-1:0] sel;
            d = $urandom_range(0, ND - 1);
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 4) == 0) cur_seg[d] = 7'($urandom_range(0, 127));
                else cur_seg[d] = glyph_tab[$urandom_range(0, 15)];
            end
            if ($urandom_range(0, 7) == 0) cur_dp = ~cur_dp;
            if ($urandom_range(0, 7) == 0) sel = 4'($urandom_range(0, 15));
            else sel = 4'(1 << d);
            cycle(1'($urandom_range(0, 3) != 0), sel, cur_seg[d], cur_dp, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
